uart_tx_mmio: RTL

Memory-mapped UART transmitter attached to the single-cycle RISC-V data bus, in parallel with `dmem`. It decodes `DataAdr` and `MemWrite` and queues written bytes in a small FIFO. Queued bytes are serialized 8N1, LSB first, on `tx`. A status register is readable through the same bus; the top-level read mux selects `ReadData` from this block when `sel` is high.

---
 rtl/uart_mmio_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/uart_tx_mmio.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM state
// encoding, register offsets relative to BASE_ADDR and STATUS bit positions.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_mmio_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } uart_state_t;

    // Register byte offsets from BASE_ADDR
    localparam logic [31:0] UART_DATA_OFS   = 32'd0;
    localparam logic [31:0] UART_STATUS_OFS = 32'd4;

    // STATUS register bit positions; occupancy lives in bits [7:4]
    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Pointers carry one extra wrap bit
// so full and empty are distinguished without a separate flag. Push and pop
// are gated internally by the pre-edge full/empty state, so a push into a
// full FIFO is rejected even when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == FULL_COUNT);
    assign empty    = (wr_ptr == rd_ptr);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; synchronous active-low reset empties the queue
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers
        // define which entries are valid, and leaving it unreset lets it map
        // onto plain RAM/register files without reset wiring.
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter sitting beside dmem on the core data bus.
// DATA (BASE_ADDR) writes queue a byte; STATUS (BASE_ADDR+4) reads return
// {count, ovf, empty, full, busy}; writing STATUS with bit 3 set clears ovf.
// Bytes go out 8N1, LSB first. Define UART_TX_PARITY_EN to insert an
// even-parity bit between the data bits and the stop bit (8E1).
module uart_tx_mmio
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          BAUD_DIV   = 434,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        sel,
    output logic        tx,
    output logic        busy
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

    // ---------------- bus decode ----------------
    logic data_hit;
    logic status_hit;
    logic data_wr;
    logic status_wr;

    assign data_hit   = (DataAdr == BASE_ADDR + UART_DATA_OFS);
    assign status_hit = (DataAdr == BASE_ADDR + UART_STATUS_OFS);
    assign sel        = data_hit || status_hit;
    assign data_wr    = MemWrite && data_hit;
    assign status_wr  = MemWrite && status_hit;

    // Only the low byte (DATA) and bit 3 (ovf clear) of the write bus matter
    logic unused_wdata;
    assign unused_wdata = ^WriteData[31:8];

    // ---------------- byte queue ----------------
    logic           fifo_pop;
    logic [7:0]     fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FCW-1:0] fifo_count;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (data_wr),
        .push_data (WriteData[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ---------------- overflow flag ----------------
    logic ovf;

    // Sticky overflow: set by a DATA write that finds the queue full
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (data_wr && fifo_full) begin
            ovf <= 1'b1;
        end else if (status_wr && WriteData[ST_OVF]) begin
            ovf <= 1'b0;
        end
    end

    // ---------------- transmitter FSM ----------------
    uart_state_t    state, state_n;
    logic [CNT_W-1:0] baud_cnt, baud_n;
    logic [2:0]     bit_idx, bit_n;
    logic [7:0]     shift, shift_n;
    logic           tx_q, tx_n;
    logic           baud_last;
`ifdef UART_TX_PARITY_EN
    logic           par_q, par_n;
`endif

    assign baud_last = (baud_cnt == BAUD_LAST);

    // State, shifter, baud counter and registered tx line
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
            tx_q     <= tx_n;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_n;
`endif
        end
    end

    // Next-state logic; the head byte is popped when a frame starts
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_n  = state;
        baud_n   = baud_last ? '0 : baud_cnt + 1'b1;
        bit_n    = bit_idx;
        shift_n  = shift;
        fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n    = par_q;
`endif
        case (state)
            S_IDLE: begin
                baud_n = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_n  = fifo_head;
`ifdef UART_TX_PARITY_EN
                    par_n    = ^fifo_head;
`endif
                    state_n  = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    state_n = S_DATA;
                    bit_n   = '0;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    shift_n = {1'b0, shift[7:1]};
                    bit_n   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_last) state_n = S_STOP;
            end
`endif
            S_STOP: begin
                if (baud_last) begin
                    if (!fifo_empty) begin
                        // Back-to-back: next START follows STOP with no gap
                        fifo_pop = 1'b1;
                        shift_n  = fifo_head;
`ifdef UART_TX_PARITY_EN
                        par_n    = ^fifo_head;
`endif
                        state_n  = S_START;
                    end else begin
                        state_n  = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                baud_n  = '0;
            end
        endcase
    end

    // Line level for the next state, registered so tx is glitch-free
    always_comb begin
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_n = par_n;
`endif
            default:  tx_n = 1'b1;
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state != S_IDLE) || !fifo_empty;

    // ---------------- STATUS / read mux ----------------
    logic [31:0] status;

    // STATUS word assembled from pre-edge registered state
    always_comb begin
        status           = '0;
        status[ST_BUSY]  = busy;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_OVF]   = ovf;
        status[7:4]      = 4'(fifo_count);
    end

    assign ReadData = status_hit ? status : 32'd0;

endmodule
